// File: rtl/decode_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// decode_stage_pipe_if : D-stage inputs, redirect outputs and E-register bus
// Revision 1.0
// ============================================================================
interface decode_stage_pipe_if #(
  parameter int DW       = 32,
  parameter int RF_DEPTH = 32,
  parameter int NFWD     = 3
);
  localparam int AW = $clog2(RF_DEPTH);
  localparam int SW = $clog2(NFWD + 1);

  logic [31:0]        pc_d;
  logic [31:0]        instr_d;
  logic               valid_d;
  logic               stall;
  logic               flush;
  logic               hold_e;
  logic [1:0]         npc_sel;
  logic [2:0]         br_cond;
  logic [1:0]         ext_op;
  logic               rf_we_w;
  logic [AW-1:0]      rf_waddr_w;
  logic [DW-1:0]      rf_wdata_w;
  logic [NFWD*DW-1:0] fwd_data;
  logic [SW-1:0]      fwd_sel_rs;
  logic [SW-1:0]      fwd_sel_rt;
  logic [31:0]        npc;
  logic               pc_src;
  logic               br_taken;
  logic [31:0]        pc_e;
  logic [31:0]        instr_e;
  logic [DW-1:0]      rs_e;
  logic [DW-1:0]      rt_e;
  logic [DW-1:0]      ext_e;
  logic               valid_e;

  modport master (
    output pc_d, instr_d, valid_d, stall, flush, hold_e, npc_sel, br_cond, ext_op,
           rf_we_w, rf_waddr_w, rf_wdata_w, fwd_data, fwd_sel_rs, fwd_sel_rt,
    input  npc, pc_src, br_taken, pc_e, instr_e, rs_e, rt_e, ext_e, valid_e
  );

  modport slave (
    input  pc_d, instr_d, valid_d, stall, flush, hold_e, npc_sel, br_cond, ext_op,
           rf_we_w, rf_waddr_w, rf_wdata_w, fwd_data, fwd_sel_rs, fwd_sel_rt,
    output npc, pc_src, br_taken, pc_e, instr_e, rs_e, rt_e, ext_e, valid_e
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// decode_stage_pipe : register file, operand forwarding, branch/next-PC
//                     resolution and D->E pipeline register.
// Option macro DECODE_WB_BYPASS_EN : same-cycle write-through on RF reads.
// Revision 1.0
// ============================================================================
module decode_stage_pipe #(
  parameter int DW       = 32,
  parameter int RF_DEPTH = 32,
  parameter int NFWD     = 3
) (
  input logic                clk,
  input logic                reset,
  decode_stage_pipe_if.slave bus
);
  localparam int AW = $clog2(RF_DEPTH);
  localparam int SW = $clog2(NFWD + 1);

  localparam logic [1:0] c_npc_seq  = 2'd0;
  localparam logic [1:0] c_npc_br   = 2'd1;
  localparam logic [1:0] c_npc_j    = 2'd2;
  localparam logic [1:0] c_npc_jr   = 2'd3;

  localparam logic [2:0] c_br_eq    = 3'd0;
  localparam logic [2:0] c_br_ne    = 3'd1;
  localparam logic [2:0] c_br_lez   = 3'd2;
  localparam logic [2:0] c_br_gtz   = 3'd3;
  localparam logic [2:0] c_br_ltz   = 3'd4;
  localparam logic [2:0] c_br_gez   = 3'd5;

  localparam logic [1:0] c_ext_sign = 2'd1;
  localparam logic [1:0] c_ext_lui  = 2'd2;

  logic [DW-1:0] rf_q [RF_DEPTH];
  logic [DW-1:0] rf_d [RF_DEPTH];

  logic [4:0]    rs_fld;
  logic [4:0]    rt_fld;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rf_rs;
  logic [DW-1:0] rf_rt;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [15:0]   imm16;
  logic [31:0]   pc4;
  logic [31:0]   br_off;
  logic          cond_ok;
  logic          taken;
  logic [31:0]   npc_val;
  logic [DW-1:0] ext_val;

  logic [31:0]   pc_e_q,    pc_e_d;
  logic [31:0]   instr_e_q, instr_e_d;
  logic [DW-1:0] rs_e_q,    rs_e_d;
  logic [DW-1:0] rt_e_q,    rt_e_d;
  logic [DW-1:0] ext_e_q,   ext_e_d;
  logic          valid_e_q, valid_e_d;

  assign rs_fld  = bus.instr_d[25:21];
  assign rt_fld  = bus.instr_d[20:16];
  assign rs_addr = rs_fld[AW-1:0];
  assign rt_addr = rt_fld[AW-1:0];
  assign imm16   = bus.instr_d[15:0];

  // Register 0 is never written, so its storage stays at the reset value.
  always_comb begin
    rf_d = rf_q;
    if (bus.rf_we_w && (bus.rf_waddr_w != '0)) begin
      rf_d[bus.rf_waddr_w] = bus.rf_wdata_w;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_q <= '{default: '0};
    end else begin
      rf_q <= rf_d;
    end
  end

  always_comb begin
    rf_rs = (rs_addr == '0) ? '0 : rf_q[rs_addr];
    rf_rt = (rt_addr == '0) ? '0 : rf_q[rt_addr];
`ifdef DECODE_WB_BYPASS_EN
    if (bus.rf_we_w && (bus.rf_waddr_w != '0) && (bus.rf_waddr_w == rs_addr)) begin
      rf_rs = bus.rf_wdata_w;
    end
    if (bus.rf_we_w && (bus.rf_waddr_w != '0) && (bus.rf_waddr_w == rt_addr)) begin
      rf_rt = bus.rf_wdata_w;
    end
`endif
  end

  // Selector k picks source k-1; 0 and any out-of-range code fall back to the RF.
  always_comb begin
    op_a = rf_rs;
    op_b = rf_rt;
    for (int k = 0; k < NFWD; k++) begin
      if (bus.fwd_sel_rs == SW'(k + 1)) op_a = bus.fwd_data[k*DW +: DW];
      if (bus.fwd_sel_rt == SW'(k + 1)) op_b = bus.fwd_data[k*DW +: DW];
    end
  end

  always_comb begin
    cond_ok = 1'b0;
    case (bus.br_cond)
      c_br_eq:  cond_ok = (op_a == op_b);
      c_br_ne:  cond_ok = (op_a != op_b);
      c_br_lez: cond_ok = op_a[DW-1] || (op_a == '0);
      c_br_gtz: cond_ok = !op_a[DW-1] && (op_a != '0);
      c_br_ltz: cond_ok = op_a[DW-1];
      c_br_gez: cond_ok = !op_a[DW-1];
      default:  cond_ok = 1'b0;
    endcase
  end

  assign pc4    = bus.pc_d + 32'd4;
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign taken  = (bus.npc_sel == c_npc_br) && cond_ok;

  always_comb begin
    npc_val = pc4;
    case (bus.npc_sel)
      c_npc_seq: npc_val = pc4;
      c_npc_br:  npc_val = taken ? (pc4 + br_off) : pc4;
      c_npc_j:   npc_val = {pc4[31:28], bus.instr_d[25:0], 2'b00};
      c_npc_jr:  npc_val = op_a[31:0];
      default:   npc_val = pc4;
    endcase
  end

  assign bus.npc      = npc_val;
  assign bus.br_taken = taken;
  assign bus.pc_src   = bus.valid_d && !bus.stall && !bus.flush &&
                        ((bus.npc_sel == c_npc_j) || (bus.npc_sel == c_npc_jr) || taken);

  always_comb begin
    case (bus.ext_op)
      c_ext_sign: ext_val = DW'($signed(imm16));
      c_ext_lui:  ext_val = DW'({imm16, 16'h0000});
      default:    ext_val = DW'(imm16);
    endcase
  end

  // hold_e outranks stall/flush: a frozen E stage must not be overwritten by a bubble.
  always_comb begin
    pc_e_d    = pc_e_q;
    instr_e_d = instr_e_q;
    rs_e_d    = rs_e_q;
    rt_e_d    = rt_e_q;
    ext_e_d   = ext_e_q;
    valid_e_d = valid_e_q;
    if (!bus.hold_e) begin
      if (bus.stall || bus.flush || !bus.valid_d) begin
        pc_e_d    = '0;
        instr_e_d = '0;
        rs_e_d    = '0;
        rt_e_d    = '0;
        ext_e_d   = '0;
        valid_e_d = 1'b0;
      end else begin
        pc_e_d    = bus.pc_d;
        instr_e_d = bus.instr_d;
        rs_e_d    = op_a;
        rt_e_d    = op_b;
        ext_e_d   = ext_val;
        valid_e_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_e_q    <= '0;
      instr_e_q <= '0;
      rs_e_q    <= '0;
      rt_e_q    <= '0;
      ext_e_q   <= '0;
      valid_e_q <= 1'b0;
    end else begin
      pc_e_q    <= pc_e_d;
      instr_e_q <= instr_e_d;
      rs_e_q    <= rs_e_d;
      rt_e_q    <= rt_e_d;
      ext_e_q   <= ext_e_d;
      valid_e_q <= valid_e_d;
    end
  end

  assign bus.pc_e    = pc_e_q;
  assign bus.instr_e = instr_e_q;
  assign bus.rs_e    = rs_e_q;
  assign bus.rt_e    = rt_e_q;
  assign bus.ext_e   = ext_e_q;
  assign bus.valid_e = valid_e_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// tb_decode_stage_pipe : directed and random stimulus against a behavioural model
// Revision 1.0
// ============================================================================
module tb_decode_stage_pipe;
  localparam int DW       = 32;
  localparam int RF_DEPTH = 32;
  localparam int NFWD     = 3;
  localparam int AW       = $clog2(RF_DEPTH);
  localparam int SW       = $clog2(NFWD + 1);

  logic clk;
  logic reset;

  decode_stage_pipe_if #(.DW(DW), .RF_DEPTH(RF_DEPTH), .NFWD(NFWD)) bus ();

  decode_stage_pipe #(.DW(DW), .RF_DEPTH(RF_DEPTH), .NFWD(NFWD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  logic [DW-1:0] m_rf [RF_DEPTH];
  logic [31:0]   e_pc, e_instr;
  logic [DW-1:0] e_rs, e_rt, e_ext;
  logic          e_valid;
  logic [31:0]   n_pc, n_instr;
  logic [DW-1:0] n_rs, n_rt, n_ext;
  logic          n_valid;
  logic          n_we;
  int            n_wa;
  logic [DW-1:0] n_wd;
  logic [31:0]   snap_pc, snap_instr;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int rs, input int rt, input logic [15:0] imm);
    logic [4:0] a;
    logic [4:0] b;
    a = 5'(rs);
    b = 5'(rt);
    return {6'h04, a, b, imm};
  endfunction

  function automatic logic [DW-1:0] rf_rd(input int a);
    if (a == 0) return '0;
`ifdef DECODE_WB_BYPASS_EN
    if (bus.rf_we_w && int'(bus.rf_waddr_w) == a) return bus.rf_wdata_w;
`endif
    return m_rf[a];
  endfunction

  function automatic logic [DW-1:0] pick(input int sel, input logic [DW-1:0] rfv);
    if (sel >= 1 && sel <= NFWD) return bus.fwd_data[(sel-1)*DW +: DW];
    return rfv;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < RF_DEPTH; i++) m_rf[i] = '0;
    e_pc = '0; e_instr = '0; e_rs = '0; e_rt = '0; e_ext = '0; e_valid = 1'b0;
  endtask

  task automatic set_idle();
    bus.pc_d = '0; bus.instr_d = '0; bus.valid_d = 1'b0;
    bus.stall = 1'b0; bus.flush = 1'b0; bus.hold_e = 1'b0;
    bus.npc_sel = '0; bus.br_cond = '0; bus.ext_op = '0;
    bus.rf_we_w = 1'b0; bus.rf_waddr_w = '0; bus.rf_wdata_w = '0;
    bus.fwd_data = '0; bus.fwd_sel_rs = '0; bus.fwd_sel_rt = '0;
  endtask

  task automatic comb_check();
    logic [DW-1:0] a, b, x;
    longint        sa, sb;
    logic          c, tk, src;
    int            off;
    logic [31:0]   pc4, np;
    logic [15:0]   imm;
    #2;
    imm = bus.instr_d[15:0];
    a   = pick(int'(bus.fwd_sel_rs), rf_rd(int'(bus.instr_d[25:21]) % RF_DEPTH));
    b   = pick(int'(bus.fwd_sel_rt), rf_rd(int'(bus.instr_d[20:16]) % RF_DEPTH));
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    case (int'(bus.br_cond))
      0: c = (sa == sb);
      1: c = (sa != sb);
      2: c = (sa <= 0);
      3: c = (sa > 0);
      4: c = (sa < 0);
      5: c = (sa >= 0);
      default: c = 1'b0;
    endcase
    tk  = (int'(bus.npc_sel) == 1) && c;
    pc4 = bus.pc_d + 32'd4;
    off = int'($signed(imm)) * 4;
    case (int'(bus.npc_sel))
      0: np = pc4;
      1: np = tk ? pc4 + 32'(off) : pc4;
      2: np = (pc4 & 32'hF000_0000) | (32'(bus.instr_d[25:0]) * 32'd4);
      default: np = a[31:0];
    endcase
    src = bus.valid_d && !bus.stall && !bus.flush && (int'(bus.npc_sel) >= 2 || tk);
    case (int'(bus.ext_op))
      1: x = DW'(longint'($signed(imm)));
      2: x = DW'(longint'(imm) * 65536);
      default: x = DW'(imm);
    endcase
    if (bus.hold_e) begin
      n_pc = e_pc; n_instr = e_instr; n_rs = e_rs; n_rt = e_rt; n_ext = e_ext; n_valid = e_valid;
    end else if (bus.stall || bus.flush || !bus.valid_d) begin
      n_pc = '0; n_instr = '0; n_rs = '0; n_rt = '0; n_ext = '0; n_valid = 1'b0;
    end else begin
      n_pc = bus.pc_d; n_instr = bus.instr_d; n_rs = a; n_rt = b; n_ext = x; n_valid = 1'b1;
    end
    n_we = bus.rf_we_w;
    n_wa = int'(bus.rf_waddr_w);
    n_wd = bus.rf_wdata_w;
    check_val("npc", bus.npc, np);
    check_val("pc_src", bus.pc_src, src);
    check_val("br_taken", bus.br_taken, tk);
  endtask

  task automatic edge_check();
    @(posedge clk);
    if (n_we && n_wa != 0) m_rf[n_wa] = n_wd;
    e_pc = n_pc; e_instr = n_instr; e_rs = n_rs; e_rt = n_rt; e_ext = n_ext; e_valid = n_valid;
    #1;
    check_val("pc_e", bus.pc_e, e_pc);
    check_val("instr_e", bus.instr_e, e_instr);
    check_val("rs_e", bus.rs_e, e_rs);
    check_val("rt_e", bus.rt_e, e_rt);
    check_val("ext_e", bus.ext_e, e_ext);
    check_val("valid_e", bus.valid_e, e_valid);
  endtask

  task automatic cycle();
    comb_check();
    edge_check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    set_idle();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_valid_e", bus.valid_e, 0);
    check_val("rst_pc_e", bus.pc_e, 0);
    check_val("rst_rs_e", bus.rs_e, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // r5 write then read; r0 write ignored
    set_idle(); bus.rf_we_w = 1'b1; bus.rf_waddr_w = AW'(5); bus.rf_wdata_w = DW'(32'h1234);
    cycle();
    set_idle(); bus.instr_d = mk(5, 0, 16'h0); bus.valid_d = 1'b1;
    cycle();
    check_val("r5_rs_e", bus.rs_e, 64'h1234);
    check_val("r5_valid_e", bus.valid_e, 1);
    set_idle(); bus.rf_we_w = 1'b1; bus.rf_waddr_w = '0; bus.rf_wdata_w = DW'(32'hFFFF);
    cycle();
    set_idle(); bus.instr_d = mk(0, 0, 16'h0); bus.valid_d = 1'b1;
    cycle();
    check_val("r0_rs_e", bus.rs_e, 0);

    // beq backwards by one instruction
    set_idle(); bus.pc_d = 32'h3000; bus.instr_d = mk(1, 2, 16'hFFFF); bus.valid_d = 1'b1;
    bus.npc_sel = 2'd1; bus.br_cond = 3'd0;
    bus.fwd_data[0 +: DW] = DW'(32'h55); bus.fwd_data[DW +: DW] = DW'(32'h66);
    bus.fwd_sel_rs = SW'(1); bus.fwd_sel_rt = SW'(1);
    comb_check();
    check_val("beq_eq_npc", bus.npc, 32'h3000);
    check_val("beq_eq_src", bus.pc_src, 1);
    edge_check();
    bus.fwd_sel_rt = SW'(2);
    comb_check();
    check_val("beq_ne_npc", bus.npc, 32'h3004);
    check_val("beq_ne_src", bus.pc_src, 0);
    edge_check();

    // jr through forwarding source 1, then with stall
    set_idle(); bus.pc_d = 32'h100; bus.instr_d = mk(9, 0, 16'h0); bus.valid_d = 1'b1;
    bus.npc_sel = 2'd3; bus.fwd_sel_rs = SW'(2); bus.fwd_data[DW +: DW] = DW'(32'h0040_0010);
    comb_check();
    check_val("jr_npc", bus.npc, 32'h0040_0010);
    check_val("jr_src", bus.pc_src, 1);
    edge_check();
    bus.stall = 1'b1;
    comb_check();
    check_val("jr_stall_src", bus.pc_src, 0);
    edge_check();
    check_val("jr_stall_valid_e", bus.valid_e, 0);

    // hold_e beats flush for three cycles, then flush bubbles
    set_idle(); bus.pc_d = 32'h2220; bus.instr_d = mk(5, 0, 16'h8001); bus.valid_d = 1'b1;
    bus.ext_op = 2'd1;
    cycle();
    snap_pc = bus.pc_e;
    snap_instr = bus.instr_e;
    bus.pc_d = 32'h9990; bus.hold_e = 1'b1; bus.flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("hold_pc_e", bus.pc_e, 32'h2220);
      check_val("hold_instr_e", bus.instr_e, snap_instr);
    end
    bus.hold_e = 1'b0;
    cycle();
    check_val("flush_valid_e", bus.valid_e, 0);
    check_val("flush_pc_e", bus.pc_e, 0);

    // same-cycle write and read of r7
    set_idle(); bus.rf_we_w = 1'b1; bus.rf_waddr_w = AW'(7); bus.rf_wdata_w = DW'(32'h11);
    cycle();
    bus.rf_wdata_w = DW'(32'hAA); bus.instr_d = mk(7, 7, 16'h0); bus.valid_d = 1'b1;
    cycle();
`ifdef DECODE_WB_BYPASS_EN
    check_val("wb_same_cycle", bus.rs_e, 64'hAA);
`else
    check_val("wb_same_cycle", bus.rs_e, 64'h11);
`endif

    // asynchronous reset between edges
    set_idle(); bus.pc_d = 32'h44; bus.instr_d = mk(1, 2, 16'h7); bus.valid_d = 1'b1;
    cycle();
    check_val("pre_rst_valid_e", bus.valid_e, 1);
    #2 reset = 1'b0;
    #1;
    check_val("async_valid_e", bus.valid_e, 0);
    check_val("async_pc_e", bus.pc_e, 0);
    check_val("async_instr_e", bus.instr_e, 0);
    check_val("async_rs_e", bus.rs_e, 0);
    check_val("async_rt_e", bus.rt_e, 0);
    check_val("async_ext_e", bus.ext_e, 0);
    m_reset();
    bus.rf_we_w = 1'b1; bus.rf_waddr_w = AW'(3); bus.rf_wdata_w = DW'(32'h77);
    @(posedge clk);
    #1;
    reset = 1'b1;
    set_idle(); bus.instr_d = mk(5, 7, 16'h0); bus.valid_d = 1'b1;
    cycle();
    check_val("post_rst_r5", bus.rs_e, 0);
    check_val("post_rst_r7", bus.rt_e, 0);
    bus.instr_d = mk(3, 0, 16'h0);
    cycle();
    check_val("post_rst_r3", bus.rs_e, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.pc_d       = $urandom;
      bus.instr_d    = $urandom;
      bus.valid_d    = ($urandom_range(0, 7) != 0);
      bus.stall      = ($urandom_range(0, 7) == 0);
      bus.flush      = ($urandom_range(0, 9) == 0);
      bus.hold_e     = ($urandom_range(0, 9) == 0);
      bus.npc_sel    = 2'($urandom);
      bus.br_cond    = 3'($urandom);
      bus.ext_op     = 2'($urandom);
      bus.rf_we_w    = 1'($urandom);
      bus.rf_waddr_w = AW'($urandom);
      bus.rf_wdata_w = DW'({$urandom, $urandom});
      for (int k = 0; k < NFWD; k++) bus.fwd_data[k*DW +: DW] = DW'({$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) bus.fwd_data[DW +: DW] = bus.fwd_data[0 +: DW];
      if ($urandom_range(0, 5) == 0) bus.fwd_data[0 +: DW] = '0;
      bus.fwd_sel_rs = SW'($urandom);
      bus.fwd_sel_rt = SW'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/decode_stage_pipe.md
DECODE_STAGE_PIPE -- requirements
Module: decode_stage_pipe

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register/operand data width; legal values are 32 or 64.
REQ-002 SHALL have parameter RF_DEPTH, default 32, meaning register count; it is a power of two, and AW = log2(RF_DEPTH).
REQ-003 SHALL have parameter NFWD, default 3, meaning forwarding source count (1..4); SW = log2(NFWD+1) rounded up.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have ports pc_d in 32, instr_d in 32, valid_d in 1: the D-stage instruction, its PC, and its valid flag.
REQ-007 SHALL have ports stall in 1 (hazard: insert bubble into E), flush in 1 (kill D: insert bubble into E), and hold_e in 1 (freeze E register).
REQ-008 SHALL have port npc_sel, input, 2 bits: 0 = pc+4, 1 = conditional branch, 2 = j imm26, 3 = jr.
REQ-009 SHALL have port br_cond, input, 3 bits: 0 eq, 1 ne, 2 lez, 3 gtz, 4 ltz, 5 gez; codes 6 and 7 mean never taken.
REQ-010 SHALL have port ext_op, input, 2 bits: 0 zero-extend, 1 sign-extend, 2 imm16 shifted left by 16, 3 zero-extend.
REQ-011 SHALL have write-back ports rf_we_w in 1, rf_waddr_w in AW, rf_wdata_w in DW.
REQ-012 SHALL have ports fwd_data in NFWD*DW, where source k occupies bits [k*DW +: DW], plus fwd_sel_rs in SW and fwd_sel_rt in SW; selector value 0 means register file, k means source k-1, and values above NFWD mean register file.
REQ-013 SHALL have outputs npc out 32, pc_src out 1 (redirect), and br_taken out 1.
REQ-014 SHALL have registered outputs pc_e out 32, instr_e out 32, rs_e out DW, rt_e out DW, ext_e out DW, and valid_e out 1.

Function
REQ-015 SHALL decode rs = instr_d[25:21] and rt = instr_d[20:16], using the low AW bits for register file indexing.
REQ-016 SHALL write the register file at a rising edge when rf_we_w = 1 and rf_waddr_w != 0; register 0 always reads 0.
REQ-017 SHALL read the register file combinationally; operand A/B = the forwarding mux output selected by fwd_sel_rs/fwd_sel_rt.
REQ-018 SHALL compare signed operand A and operand B per br_cond; the lez/gtz/ltz/gez conditions use operand A only.
REQ-019 SHALL compute pc4 = pc_d+4 (mod 2^32).
REQ-020 SHALL compute npc as pc4 for npc_sel 0.
REQ-021 SHALL compute npc as pc4 + (sext(imm16)<<2) when npc_sel = 1 and the condition holds, and as pc4 otherwise.
REQ-022 SHALL compute npc as {pc4[31:28], imm26, 2'b00} for npc_sel 2, and as operand A[31:0] for npc_sel 3.
REQ-023 SHALL assert br_taken when npc_sel = 1 and the condition holds.
REQ-024 SHALL assert pc_src = valid_d & ~stall & ~flush & (npc_sel = 2, npc_sel = 3, or br_taken); all of this logic is combinational, with zero latency.
REQ-025 SHALL update the E register each edge by priority: hold_e → keep all E contents; else stall, flush or ~valid_d → bubble (all E fields 0, valid_e 0); else load pc_d, instr_d, operand A, operand B, the extended immediate, and valid_e = 1.
REQ-026 SHALL, when stall and flush are asserted together, produce a single bubble, identical to asserting either alone.
REQ-027 SHALL, when hold_e is asserted with stall or flush, let hold_e win, so the E contents are unchanged that cycle.

Reset
REQ-028 SHALL, while reset = 0, immediately clear all E outputs to 0, clear valid_e to 0, and clear all registers to 0, independent of clk.
REQ-029 SHALL, on deassertion mid-operation, resume normal loading at the first rising edge with reset = 1, discarding any write presented during reset.

Configuration
REQ-030 SHALL, with macro DECODE_WB_BYPASS_EN defined, return rf_wdata_w on a register read when rf_we_w = 1 and the read address equals a nonzero rf_waddr_w in the same cycle (write-through).
REQ-031 SHALL, without DECODE_WB_BYPASS_EN, return the pre-write register value on such a read; same-cycle write-back forwarding is then the hazard unit's duty via fwd_data.

Verification
REQ-032 SHALL cover: write r5 = 0x1234 and then read r5 with the selectors at 0 → rs_e = 0x00001234 and valid_e = 1 after one edge; write r0 = 0xFFFF → r0 still reads 0.
REQ-033 SHALL cover: beq with pc_d = 0x3000, imm16 = 0xFFFF and operands equal → npc = 0x3000, pc_src = 1; operands unequal → npc = 0x3004, pc_src = 0.
REQ-034 SHALL cover: jr with fwd_sel_rs = 2 and source 1 = 0x00400010 → npc = 0x00400010, pc_src = 1; the same with stall = 1 → pc_src = 0 and valid_e = 0 after the edge.
REQ-035 SHALL cover: load the E register, then assert hold_e and flush for 3 cycles → E outputs unchanged; release hold_e with flush still high → bubble at the next edge.
REQ-036 SHALL cover: same-cycle write r7 = 0xAA with a read of r7 whose old value is 0x11 → rs_e = 0xAA with DECODE_WB_BYPASS_EN defined, and 0x11 without it.
REQ-037 SHALL cover: assert reset low between edges while valid_e = 1 → valid_e and all E fields read 0 before the next edge; registers read 0 after release.
